// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// writes them to imem from address 0 and holds the core in reset until the image is in.
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count
);

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [1:0]            r_idx;
    logic [31:0]           r_asm;
    // The write pointer doubles as the word count: both advance only on a real write.
    logic [ADDR_WIDTH:0]   r_wptr;
    logic                  r_ready;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_cpu_rst;
    logic                  r_done;
    logic                  r_overflow;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_full;
    logic [31:0]           w_word;

    assign w_accept   = in_valid && r_ready && (r_state == LOAD);
    assign w_complete = w_accept && ((r_idx == 2'd3) || in_last);
    assign w_full     = (r_wptr == CAPACITY);

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_word = r_asm;
        w_word[8*r_idx +: 8] = in_data;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept && in_last) begin
            w_state_next = DONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_idx      <= 2'd0;
            r_asm      <= 32'd0;
            r_wptr     <= '0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_ready <= (w_state_next == LOAD);
            // Release the core one cycle after DONE is entered, behind the final write pulse.
            if (r_state == DONE) begin
                r_cpu_rst <= 1'b0;
            end
            if (w_accept) begin
                if (w_complete) begin
                    r_idx <= 2'd0;
                    r_asm <= 32'd0;
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_we    <= 1'b1;
                        r_addr  <= r_wptr[ADDR_WIDTH-1:0];
                        r_wdata <= w_word;
                        r_wptr  <= r_wptr + (ADDR_WIDTH+1)'(1);
                    end
                end else begin
                    r_idx <= r_idx + 2'd1;
                    r_asm <= w_word;
                end
                if (in_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign in_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_wptr;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a 1024-word and a 4-word instance share one byte stream and
// are checked against an image-level model of the expected imem writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;

    logic        b_ready, b_we, b_cpu_rst, b_done, b_ovf;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata;
    logic [10:0] b_wc;
    logic        s_ready, s_we, s_cpu_rst, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_wc;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(10)) dut_big (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_rst(b_cpu_rst), .done(b_done), .overflow(b_ovf), .word_count(b_wc)
    );

    imem_loader #(.ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .cpu_rst(s_cpu_rst), .done(s_done), .overflow(s_ovf), .word_count(s_wc)
    );

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [7:0]  q_bytes[$];
    int          q_acc[$];
    wr_t         wr_big[$];
    wr_t         wr_small[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic wr_t mk_wr(input int c, input int a, input logic [31:0] d);
        wr_t w;
        w.cyc  = c;
        w.addr = a;
        w.data = d;
        return w;
    endfunction

    always @(negedge clk) begin
        if (b_we === 1'b1) wr_big.push_back(mk_wr(cyc, int'(b_addr), b_wdata));
        if (s_we === 1'b1) wr_small.push_back(mk_wr(cyc, int'(s_addr), s_wdata));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected word k of the image: bytes 4k..4k+3, first byte in the low lane, missing bytes zero.
    function automatic logic [31:0] model_word(input int k);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
            if (4*k + j < q_bytes.size()) w = w + (32'(q_bytes[4*k + j]) << (8*j));
        end
        return w;
    endfunction

    task automatic do_reset();
        rstn     = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("big_rst_ready",    64'(b_ready),   64'd0);
        check("big_rst_we",       64'(b_we),      64'd0);
        check("big_rst_addr",     64'(b_addr),    64'd0);
        check("big_rst_wdata",    64'(b_wdata),   64'd0);
        check("big_rst_cpu_rst",  64'(b_cpu_rst), 64'd1);
        check("big_rst_done",     64'(b_done),    64'd0);
        check("big_rst_ovf",      64'(b_ovf),     64'd0);
        check("big_rst_wc",       64'(b_wc),      64'd0);
        check("small_rst_ready",  64'(s_ready),   64'd0);
        check("small_rst_cpu_rst",64'(s_cpu_rst), 64'd1);
        check("small_rst_done",   64'(s_done),    64'd0);
        check("small_rst_wc",     64'(s_wc),      64'd0);
        rstn = 1'b0;
        wr_big.delete();
        wr_small.delete();
        q_acc.delete();
    endtask

    // Called and returns at a falling edge; bytes in q_bytes, random idle gaps up to max_gap.
    task automatic send_stream(input bit with_last, input int max_gap);
        q_acc.delete();
        foreach (q_bytes[i]) begin
            int gap;
            int tries;
            gap = (i == 0) ? 0 : int'($urandom_range(max_gap, 0));
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = q_bytes[i];
            in_last  = with_last && (i == q_bytes.size() - 1);
            tries = 0;
            while (b_ready !== 1'b1 && tries < 16) begin
                @(negedge clk);
                tries++;
            end
            check("ready_for_byte", 64'(b_ready), 64'd1);
            @(negedge clk);
            q_acc.push_back(cyc);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'(($urandom));
        if (with_last) begin
            check("big_done_next",     64'(b_done),    64'd1);
            check("big_ready_drop",    64'(b_ready),   64'd0);
            check("big_cpu_rst_hold",  64'(b_cpu_rst), 64'd1);
            check("small_done_next",   64'(s_done),    64'd1);
            check("small_ready_drop",  64'(s_ready),   64'd0);
            check("small_cpu_rst_hold",64'(s_cpu_rst), 64'd1);
            @(negedge clk);
            check("big_cpu_rst_fall",  64'(b_cpu_rst), 64'd0);
            check("small_cpu_rst_fall",64'(s_cpu_rst), 64'd0);
        end
        @(negedge clk);
    endtask

    task automatic check_image(input bit with_last);
        int n;
        int nw;
        n  = q_bytes.size();
        nw = with_last ? (n + 3) / 4 : n / 4;
        for (int d = 0; d < 2; d++) begin
            int          cap;
            int          exp_n;
            int          got_n;
            int          idx;
            string       sfx;
            wr_t         w;
            logic [31:0] last_word;
            logic [63:0] o_ready, o_we, o_addr, o_wdata, o_cpu_rst, o_done, o_ovf, o_wc;
            cap   = (d == 0) ? 1024 : 4;
            sfx   = (d == 0) ? "big" : "small";
            exp_n = (nw < cap) ? nw : cap;
            got_n = (d == 0) ? wr_big.size() : wr_small.size();
            check({sfx, "_write_count"}, 64'(got_n), 64'(exp_n));
            last_word = 32'd0;
            for (int k = 0; k < exp_n; k++) begin
                last_word = model_word(k);
                if (k < got_n) begin
                    w   = (d == 0) ? wr_big[k] : wr_small[k];
                    idx = (4*k + 3 < n) ? 4*k + 3 : n - 1;
                    check({sfx, "_write_addr"},  64'(w.addr), 64'(k));
                    check({sfx, "_write_data"},  64'(w.data), 64'(last_word));
                    check({sfx, "_write_cycle"}, 64'(w.cyc),  64'(q_acc[idx]));
                end
            end
            if (d == 0) begin
                o_ready = 64'(b_ready); o_we = 64'(b_we); o_addr = 64'(b_addr); o_wdata = 64'(b_wdata);
                o_cpu_rst = 64'(b_cpu_rst); o_done = 64'(b_done); o_ovf = 64'(b_ovf); o_wc = 64'(b_wc);
            end else begin
                o_ready = 64'(s_ready); o_we = 64'(s_we); o_addr = 64'(s_addr); o_wdata = 64'(s_wdata);
                o_cpu_rst = 64'(s_cpu_rst); o_done = 64'(s_done); o_ovf = 64'(s_ovf); o_wc = 64'(s_wc);
            end
            check({sfx, "_word_count"}, o_wc,      64'(exp_n));
            check({sfx, "_overflow"},   o_ovf,     64'(nw > cap));
            check({sfx, "_done"},       o_done,    64'(with_last));
            check({sfx, "_cpu_rst"},    o_cpu_rst, 64'(!with_last));
            check({sfx, "_ready"},      o_ready,   64'(!with_last));
            check({sfx, "_we_idle"},    o_we,      64'd0);
            check({sfx, "_addr_hold"},  o_addr,    64'((exp_n > 0) ? exp_n - 1 : 0));
            check({sfx, "_wdata_hold"}, o_wdata,   64'(last_word));
        end
    endtask

    task automatic random_bytes(input int n);
        q_bytes.delete();
        for (int i = 0; i < n; i++) q_bytes.push_back(8'($urandom));
    endtask

    initial begin
        rstn     = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        @(negedge clk);

        // Two-instruction program, continuous valid.
        do_reset();
        q_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
        send_stream(1'b1, 0);
        check_image(1'b1);
        check("prog_word0", 64'(wr_big[0].data), 64'h0050_0513);
        check("prog_word1", 64'(wr_big[1].data), 64'h0060_0593);

        // Partial final word is zero padded.
        do_reset();
        q_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_stream(1'b1, 0);
        check_image(1'b1);
        check("partial_word1", 64'(wr_big[1].data), 64'h0000_0055);

        // Same program with idle gaps between bytes.
        do_reset();
        q_bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
        send_stream(1'b1, 3);
        check_image(1'b1);

        // 20 bytes: fits the large instance, overflows the 4-word one.
        do_reset();
        random_bytes(20);
        send_stream(1'b1, 0);
        check_image(1'b1);

        // After done the stream is ignored and every output holds.
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            check("big_done_ready",   64'(b_ready), 64'd0);
            check("small_done_ready", 64'(s_ready), 64'd0);
            check("big_done_we",      64'(b_we),    64'd0);
            check("small_done_we",    64'(s_we),    64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_image(1'b1);

        // Reset in the middle of the second word.
        do_reset();
        random_bytes(6);
        send_stream(1'b0, 1);
        check_image(1'b0);
        do_reset();
        q_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_stream(1'b1, 0);
        check_image(1'b1);
        check("after_reset_word0", 64'(wr_big[0].data), 64'hDDCC_BBAA);

        // Single byte with last on an empty word.
        do_reset();
        random_bytes(1);
        send_stream(1'b1, 2);
        check_image(1'b1);

        // Random images of random length and pacing.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            random_bytes(int'($urandom_range(30, 1)));
            send_stream(1'b1, 3);
            check_image(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Synthesizable writer for the single-cycle core's instruction memory. Receives a little-endian byte stream over a valid/ready handshake, packs it into 32-bit words and writes them to consecutive imem word addresses starting at 0.
- Holds the core in reset (cpu_rst) until loading completes, then releases it.
- Replaces simulation-only hex preloading, so a program can be loaded on the board through a UART/debug byte source.

Parameters:
- ADDR_WIDTH, 10, imem word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  synchronous, active-high reset.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte.
- in_last  in  1  qualifies the final byte of the image; meaningful only while in_valid.
- in_ready  out  1  loader accepts a byte this cycle; registered.
- imem_we  out  1  one-cycle imem write strobe.
- imem_addr  out  ADDR_WIDTH  imem word address.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  reset to the core; high while loading.
- done  out  1  image fully written; sticky until reset.
- overflow  out  1  image exceeded capacity; sticky until reset.
- word_count  out  ADDR_WIDTH+1  number of words written.

Behaviour:
- States: LOAD and DONE. DONE is terminal until rstn.
- Reset values (rstn=1 at an edge): state=LOAD; byte index=0; assembly register=0; write pointer=0; in_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; cpu_rst=1; done=0; overflow=0; word_count=0.
- in_ready is registered:
  - 1 from the first cycle after reset deassertion while in LOAD.
  - Drops to 0 the cycle after the in_last byte is accepted.
  - Stays 0 in DONE.
- Byte accept: in_valid && in_ready at a rising edge.
  - The byte is placed in lane [8*idx+7 : 8*idx] of the assembly register; idx increments mod 4.
  - Bytes are little-endian: the first byte goes to [7:0].
- Word completion occurs on acceptance of the byte with idx==3, or of any byte with in_last=1.
  - Next cycle: imem_we=1 for exactly one cycle, imem_addr = write pointer, imem_wdata = assembled word.
  - On a partial final word, unfilled upper bytes are 0.
  - Then the write pointer and word_count increment, and the assembly register and idx clear.
  - Write latency: 1 cycle from the accepting edge.
- Capacity:
  - If word_count == 2^ADDR_WIDTH at word completion, no write occurs (imem_we stays 0) and word_count does not change.
  - overflow is set to 1 on the following cycle.
  - The loader keeps accepting and discarding bytes until in_last.
  - The write pointer never wraps.
- in_last handling:
  - The accepting edge moves state to DONE.
  - Next cycle: done=1, in_ready=0, plus the final write pulse if one is due.
  - The cycle after that: cpu_rst=0.
  - Result: cpu_rst falls exactly 2 cycles after the in_last edge, always after the final imem_we pulse.
- in_last on the first byte of an empty word (idx==0): a single word containing only that byte is written.
- Gaps in in_valid have no effect on state. in_data and in_last are ignored when not accepted.
- In DONE: in_valid is ignored, no writes occur, and outputs hold.
- Reset mid-load:
  - The partial assembly is discarded and no write pulse is issued.
  - The pointer returns to 0 and cpu_rst returns to 1 at the reset edge.
  - Already-written imem words are not erased.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Test Plan:
- Reset, then stream 13 05 50 00 93 05 60 00 with in_last on the 8th byte, in_valid=1 continuously -> write addr0=0x00500513 and addr1=0x00600593, each a 1-cycle imem_we pulse 1 cycle after the 4th/8th accept; word_count=2; done=1 one cycle after the last accept; cpu_rst=0 two cycles after it.
- Stream 5 bytes 11 22 33 44 55 with in_last on 55 -> addr0=0x44332211, addr1=0x00000055; word_count=2; overflow=0.
- Same 8 bytes as the first scenario with in_valid gaps of 0-3 idle cycles between bytes -> identical writes and word_count; one imem_we pulse per word.
- ADDR_WIDTH=2, stream 20 bytes with in_last on the 20th -> exactly 4 writes to addr0..3; word_count=4; overflow=1; done=1; cpu_rst falls 2 cycles after the last accept.
- Assert rstn for 1 cycle after 6 bytes, then stream 4 bytes AA BB CC DD with last -> no write from the partial word; one write addr0=0xDDCCBBAA; word_count=1.
- After done, drive in_valid=1 with arbitrary bytes for 10 cycles -> in_ready=0, no imem_we, all outputs unchanged.
